store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
//  FIFO of committed stores between ROB commit and data_cache_arbiter. Drains the head entry to dcache as the
//  arbiter's store-side request (store wins arbitration), holding it until dmem_resp. Answers same-cycle load
//  forwarding queries from the load RS so loads see committed-but-undrained stores. Contents are committed: no flush.
// PARAMETERS
//  DEPTH  8  entries; power of 2, >=2; pointers are $clog2(DEPTH)+1 bits (MSB = wrap bit)
// PORTS
//  clk                         in   1   clock, rising edge
//  rst_n                       in   1   asynchronous active-low reset
//  commit_store_valid          in   1   ROB commits a store this cycle
//  commit_store_addr           in   32  byte address
//  commit_store_wmask          in   4   byte-lane write mask, nonzero
//  commit_store_wdata          in   32  store data, already lane-aligned
//  sb_full                     out  1   no free entry; ROB must not commit a store
//  sb_empty                    out  1   no valid entries
//  arbiter_store_buffer        out  1   head request valid to arbiter
//  arbiter_store_buffer_addr   out  32  head byte address (arbiter word-aligns)
//  arbiter_store_buffer_wmask  out  4   head wmask
//  arbiter_store_buffer_wdata  out  32  head wdata
//  dmem_resp                   in   1   dcache completed current request
//  fwd_load_valid              in   1   load RS issues a forwarding query
//  fwd_load_addr               in   32  load byte address
//  fwd_load_rmask              in   4   load byte-lane mask
//  fwd_hit                     out  1   youngest matching entry covers all requested bytes
//  fwd_data                    out  32  lane-aligned word from that entry
//  fwd_stall                   out  1   overlap exists but cannot be fully forwarded; load must wait
// BEHAVIOUR
//  - Reset: head/tail ptrs 0, all valid bits 0; hence sb_empty=1, sb_full=0, arbiter_store_buffer=0, addr/wmask/
//    wdata outputs 0, fwd_hit=0, fwd_stall=0, fwd_data=0. Reset mid-drain abandons the in-flight store.
//  - Full: ptr index bits equal, wrap bits differ. Empty: ptrs equal. sb_full/sb_empty decode registered ptrs.
//  - Enqueue: commit_store_valid && !sb_full writes entry at tail, tail++ at clock edge. commit_store_valid while
//    full is a protocol error: ignored, no state change. A pop in the same cycle does NOT admit an enqueue when full.
//  - Drain: arbiter_store_buffer = !sb_empty; addr/wmask/wdata driven from head entry, zero when empty; held
//    stable until dmem_resp. dmem_resp while nonempty -> clear head valid, head++ at edge. dmem_resp while empty
//    is ignored. Drain latency: entry visible at head the cycle after enqueue (earliest request cycle N+1).
//  - Simultaneous enqueue + pop (not full): both occur; count unchanged; ptrs wrap mod DEPTH independently.
//  - Single entry, enqueue + pop same cycle: old head popped, new entry becomes head next cycle, request stays high.
//  - Forwarding (combinational, valid only when fwd_load_valid, else all fwd outputs 0):
//    match = entry valid && entry.addr[31:2]==fwd_load_addr[31:2] && |(entry.wmask & fwd_load_rmask).
//    Select youngest matching entry (closest to tail, search wraps). If (sel.wmask & rmask)==rmask:
//    fwd_hit=1, fwd_data=sel.wdata, fwd_stall=0. If a match exists but coverage incomplete: fwd_stall=1,
//    fwd_hit=0, fwd_data=0. No match: all 0. Head entry being drained this cycle still participates.
//    An entry enqueued this cycle is not visible to a query until next cycle.
//  - No combinational path from commit_* to sb_full or fwd_*; dmem_resp affects state only at edge.
// TESTING
//  1 Reset: assert rst_n=0 mid-cycle with 3 entries -> outputs drop immediately; sb_empty=1, arbiter req=0.
//  2 Fill/drain: DEPTH=8, commit 8 stores addr 0x100+4i, dmem_resp tied 0 -> sb_full=1 after 8th; 9th commit
//    ignored; then dmem_resp every cycle -> 8 requests in FIFO order, addr 0x100..0x11C, then sb_empty=1.
//  3 Hold: head req addr 0x200 wmask 0xF, dmem_resp low 5 cycles -> outputs unchanged all 5; pops on 6th.
//  4 Forward: stores {0x300,4'b0011,0x0000_BEEF} then {0x300,4'b1111,0xCAFE_F00D}; query 0x302 rmask 4'b1100
//    -> fwd_hit=1, fwd_data=0xCAFE_F00D (youngest wins).
//  5 Partial: single store {0x400,4'b0001,0x0000_0011}; query 0x400 rmask 4'b0011 -> fwd_stall=1, fwd_hit=0;
//    query 0x404 -> all fwd outputs 0.
//  6 Wrap: sustained enqueue+pop each cycle for 3*DEPTH cycles -> count constant, order preserved across wrap.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: FIFO of committed stores, drained head-first to the dcache
// arbiter and searched combinationally for store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_store_valid,
  input  logic [31:0] commit_store_addr,
  input  logic [3:0]  commit_store_wmask,
  input  logic [31:0] commit_store_wdata,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        arbiter_store_buffer,
  output logic [31:0] arbiter_store_buffer_addr,
  output logic [3:0]  arbiter_store_buffer_wmask,
  output logic [31:0] arbiter_store_buffer_wdata,
  input  logic        dmem_resp,
  input  logic        fwd_load_valid,
  input  logic [31:0] fwd_load_addr,
  input  logic [3:0]  fwd_load_rmask,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic        fwd_stall
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             push;
  logic             pop;

  // Per-entry contents, flattened so the head mux and forwarding scan can index them
  logic [DEPTH-1:0][31:0] ent_addr;
  logic [DEPTH-1:0][3:0]  ent_wmask;
  logic [DEPTH-1:0][31:0] ent_wdata;
  logic [DEPTH-1:0]       fwd_match;

  // Low address bits only select lanes, which the masks already describe
  logic unused_fwd_addr_lo;
  assign unused_fwd_addr_lo = ^fwd_load_addr[1:0];

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  // Occupancy decodes purely from registered pointers, so commit_* never reaches sb_full
  assign sb_empty = (head_q == tail_q);
  assign sb_full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // A pop never frees room for an enqueue in the same cycle when full
  assign push = commit_store_valid && !sb_full;
  assign pop  = dmem_resp && !sb_empty;

  // Pointer and valid-bit next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_idx] = 1'b1;
      tail_d            = tail_q + PTR_W'(1);
    end
  end

  // Pointer and valid-bit registers; reset abandons any in-flight store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;

    // Capture the committed store when this slot is the tail
    always_comb begin
      addr_d  = addr_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;
      if (push && (tail_idx == IDX_W'(gi))) begin
        addr_d  = commit_store_addr;
        wmask_d = commit_store_wmask;
        wdata_d = commit_store_wdata;
      end
    end

    // Entry payload registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_q  <= '0;
        wmask_q <= '0;
        wdata_q <= '0;
      end else begin
        addr_q  <= addr_d;
        wmask_q <= wmask_d;
        wdata_q <= wdata_d;
      end
    end

    assign ent_addr[gi]  = addr_q;
    assign ent_wmask[gi] = wmask_q;
    assign ent_wdata[gi] = wdata_q;

    // Same word and at least one shared byte lane
    assign fwd_match[gi] = valid_q[gi] &&
                           (addr_q[31:2] == fwd_load_addr[31:2]) &&
                           (|(wmask_q & fwd_load_rmask));
  end

  // Head entry request; held until dmem_resp because head only moves on pop
  always_comb begin
    arbiter_store_buffer       = !sb_empty;
    arbiter_store_buffer_addr  = '0;
    arbiter_store_buffer_wmask = '0;
    arbiter_store_buffer_wdata = '0;
    if (!sb_empty) begin
      arbiter_store_buffer_addr  = ent_addr[head_idx];
      arbiter_store_buffer_wmask = ent_wmask[head_idx];
      arbiter_store_buffer_wdata = ent_wdata[head_idx];
    end
  end

  logic             fwd_any;
  logic [3:0]       fwd_sel_wmask;
  logic [31:0]      fwd_sel_wdata;
  logic [IDX_W-1:0] scan_idx;
  logic             fwd_cover;

  // Scan oldest to youngest from head; the last match seen is the youngest
  always_comb begin
    fwd_any       = 1'b0;
    fwd_sel_wmask = '0;
    fwd_sel_wdata = '0;
    scan_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_idx + IDX_W'(i);
      if (fwd_match[scan_idx]) begin
        fwd_any       = 1'b1;
        fwd_sel_wmask = ent_wmask[scan_idx];
        fwd_sel_wdata = ent_wdata[scan_idx];
      end
    end
  end

  assign fwd_cover = ((fwd_sel_wmask & fwd_load_rmask) == fwd_load_rmask);
  assign fwd_hit   = fwd_load_valid && fwd_any && fwd_cover;
  assign fwd_stall = fwd_load_valid && fwd_any && !fwd_cover;
  assign fwd_data  = fwd_hit ? fwd_sel_wdata : 32'h0;

endmodule
